// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a framed byte stream (LEN_LO, LEN_HI, 4*N data bytes LSB-first, XOR checksum)
// and writes the assembled 32-bit words to consecutive word addresses from 0. The core is
// held in reset until a load completes with a good checksum.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  single-cycle load request (honoured when not busy)
//   rx_data/rx_valid/rx_ready  byte stream handshake
//   mem_we/mem_addr/mem_wdata  instruction-memory write port (registered)
//   cpu_hold               keep core in reset
//   busy, done, error      load status (done/error sticky until next start)
//   words_written          words written in the current or last load
module imem_loader #(
    parameter int unsigned DEPTH         = 512,
    parameter int unsigned AW            = 9,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_written
);

    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StData, StCheck, StDone, StError
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    acc_q, acc_d;
    logic [23:0]   asm_q, asm_d;       // lanes 0..2; lane 3 comes straight from rx_data
    logic [AW:0]   wcnt_q, wcnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          rx_ready_q, rx_ready_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          hs;
    logic [15:0]   len_full;

    // rx_ready_q mirrors "state is busy", so it gates the handshake directly.
    assign hs       = rx_valid && rx_ready_q;
    assign len_full = {rx_data, len_q[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        acc_d       = acc_q;
        asm_d       = asm_q;
        wcnt_d      = wcnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;

        // Address steps past each completed write; saturates at the last word.
        if (mem_we_q && (32'(mem_addr_q) != DEPTH - 1)) begin
            mem_addr_d = mem_addr_q + 1'b1;
        end

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StLenLo;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    wcnt_d     = '0;
                    acc_d      = '0;
                    byte_cnt_d = '0;
                    cpu_hold_d = 1'b1;
                    mem_addr_d = '0;
                end
            end
            StLenLo: begin
                if (hs) begin
                    len_d[7:0] = rx_data;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (hs) begin
                    len_d[15:8] = rx_data;
                    if (32'(len_full) > DEPTH) begin
                        state_d    = StError;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (hs) begin
                    acc_d      = acc_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = {rx_data, asm_q};
                            wcnt_d      = wcnt_q + 1'b1;
                            if (32'(wcnt_q) + 1 == 32'(len_q)) begin
                                state_d = StCheck;
                            end
                        end
                    endcase
                end
            end
            StCheck: begin
                if (hs) begin
                    if (rx_data == acc_q) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = StError;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        rx_ready_d = (state_d == StLenLo) || (state_d == StLenHi) ||
                     (state_d == StData)  || (state_d == StCheck);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            acc_q       <= '0;
            asm_q       <= '0;
            wcnt_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rx_ready_q  <= 1'b0;
            cpu_hold_q  <= HOLD_AT_RESET;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            acc_q       <= acc_d;
            asm_q       <= asm_d;
            wcnt_q      <= wcnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rx_ready_q  <= rx_ready_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rx_ready      = rx_ready_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign busy          = (state_q == StLenLo) || (state_q == StLenHi) ||
                           (state_q == StData)  || (state_q == StCheck);
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-level model predicts the write sequence and
// final status; a monitor checks every write strobe against the predicted writes.
module tb_imem_loader;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready, mem_we, cpu_hold, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   words_written;

    imem_loader #(.DEPTH(DEPTH), .AW(AW), .HOLD_AT_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  frame_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] wr_log[$];
    int          wr_cyc[$];
    int          wr_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Checks every write strobe against the model's predicted write list.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && mem_we) begin
                wr_count++;
                wr_log.push_back(mem_wdata);
                wr_cyc.push_back(cyc);
                if (exp_data.size() == 0) begin
                    check("unexpected_write", {31'b0, mem_we}, 32'd0);
                end else begin
                    check("wr_addr", 32'(mem_addr), exp_addr.pop_front());
                    check("wr_data", mem_wdata, exp_data.pop_front());
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic int pick_gap(input int gapmax);
        return (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax));
    endfunction

    // Runs one load of frame_data with declared length len and checks the outcome.
    task automatic run_load(input int len, input bit force_chk, input logic [7:0] forced,
                            input int gapmax, input bit mid_start);
        logic [7:0]  chk;
        logic [7:0]  sent;
        logic [15:0] l16;
        bit          oversize, good;
        int          n;
        chk = 8'h00;
        foreach (frame_data[i]) chk ^= frame_data[i];
        sent     = force_chk ? forced : chk;
        l16      = 16'(len);
        oversize = (len > DEPTH);
        good     = !oversize && (sent == chk);
        if (!oversize) begin
            for (int i = 0; i < len; i++) begin
                exp_addr.push_back(32'(i));
                exp_data.push_back({frame_data[4*i+3], frame_data[4*i+2],
                                    frame_data[4*i+1], frame_data[4*i]});
            end
        end
        do_start();
        check("rx_ready_after_start", {31'b0, rx_ready}, 32'd1);
        check("busy_after_start", {31'b0, busy}, 32'd1);
        check("done_cleared", {31'b0, done}, 32'd0);
        send_byte(l16[7:0], pick_gap(gapmax));
        if (mid_start) begin
            @(negedge clk);
            rx_valid = 1'b0;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("busy_after_ignored_start", {31'b0, busy}, 32'd1);
        end
        send_byte(l16[15:8], pick_gap(gapmax));
        if (!oversize) begin
            foreach (frame_data[i]) send_byte(frame_data[i], pick_gap(gapmax));
            send_byte(sent, pick_gap(gapmax));
        end
        @(negedge clk);
        rx_valid = 1'b0;
        n = 0;
        while (!(done || error) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done", {31'b0, done}, {31'b0, good});
        check("error", {31'b0, error}, {31'b0, !good});
        check("cpu_hold", {31'b0, cpu_hold}, {31'b0, !good});
        check("words_written", 32'(words_written), oversize ? 32'd0 : 32'(len));
        check("rx_ready_end", {31'b0, rx_ready}, 32'd0);
        check("busy_end", {31'b0, busy}, 32'd0);
        check("writes_pending", 32'(exp_data.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
        check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_error"}, {31'b0, error}, 32'd0);
        check({tag, "_words"}, 32'(words_written), 32'd0);
        check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd1);
    endtask

    initial begin
        int base;
        fork
            monitor();
        join_none

        // Reset with rx_valid asserted; stream must be ignored afterwards.
        rst_n    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("post_rst");
        rx_valid = 1'b0;

        // Good load, N=2, back-to-back.
        frame_data = '{8'h13, 8'h09, 8'h00, 8'h11, 8'h93, 8'h04, 8'h00, 8'h00};
        run_load(2, 1'b1, 8'h9C, 0, 1'b0);
        check("good_w0_literal", wr_log[wr_log.size()-2], 32'h11000913);
        check("good_w1_literal", wr_log[wr_log.size()-1], 32'h00000493);
        check("write_interval", 32'(wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-2]), 32'd4);

        // Bad checksum: both writes still happen.
        run_load(2, 1'b1, 8'h00, 0, 1'b0);

        // Oversize length (513) then a valid reload.
        base = wr_count;
        frame_data.delete();
        run_load(513, 1'b0, 8'h00, 0, 1'b0);
        check("oversize_no_write", 32'(wr_count - base), 32'd0);
        frame_data = '{8'h13, 8'h09, 8'h00, 8'h11, 8'h93, 8'h04, 8'h00, 8'h00};
        run_load(2, 1'b0, 8'h00, 0, 1'b0);

        // Zero length with random gaps and an ignored start while busy.
        base = wr_count;
        frame_data.delete();
        run_load(0, 1'b0, 8'h00, 5, 1'b1);
        check("zero_len_no_write", 32'(wr_count - base), 32'd0);

        // Reset mid-load after 6 data bytes of an N=3 frame.
        base = wr_count;
        exp_addr.push_back(32'd0);
        exp_data.push_back(32'h44332211);
        do_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midload_one_write", 32'(wr_count - base), 32'd1);
        check("midload_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        exp_addr.delete();
        exp_data.delete();
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh N=1 load after reset must restart at address 0.
        frame_data = '{8'h78, 8'h56, 8'h34, 8'h12};
        run_load(1, 1'b0, 8'h00, 2, 1'b0);
        check("reload_literal", wr_log[wr_log.size()-1], 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
